// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU instruction sequencer: opcodes, field positions
// and FSM state encoding.
package alu_seq_pkg;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_ALU = 2'b01;
    localparam logic [1:0] OP_LI  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 30;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int FN_HI  = 3;
    localparam int FN_LO  = 0;
    localparam int LRD_HI = 25;
    localparam int LRD_LO = 21;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_LATCH  = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

endpackage

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer: accepts one instruction at a time and drives the
// register-bank/ALU control signals from a captured instruction register.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int EXEC_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [4:0]  reg1Addr,
    output logic [4:0]  reg2Addr,
    output logic [4:0]  regWrite,
    output logic [3:0]  aluControl,
    output logic [31:0] regWriteData,
    output logic        write,
    output logic        write_to_reg,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    logic [2:0]  state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [1:0]  op;
    logic [4:0]  rd;
    logic        in_flight;
    logic        unused_ir;

    assign op        = ir_q[OP_HI:OP_LO];
    assign rd        = (op == OP_LI) ? ir_q[LRD_HI:LRD_LO] : ir_q[RD_HI:RD_LO];
    assign in_flight = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                       (state_q == S_LATCH)  || (state_q == S_WRITE);
    assign unused_ir = ^{ir_q[29:26], ir_q[10:4]};

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_ALU: begin
                        state_d = S_EXEC;
                        cnt_d   = 4'(EXEC_CYCLES - 1);
                    end
                    OP_LI:   state_d = S_LATCH;
                    default: state_d = S_DONE;
                endcase
            end
            // Counter was preloaded with EXEC_CYCLES-1, so EXEC spans EXEC_CYCLES cycles.
            S_EXEC: begin
                if (cnt_q == 4'd0) state_d = S_LATCH;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_LATCH: state_d = S_WRITE;
            S_WRITE: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode only registered state, so reset clears them without a clock.
    always_comb begin
        instr_ready  = (state_q == S_IDLE) && !reset;
        busy         = (state_q != S_IDLE);
        reg1Addr     = '0;
        reg2Addr     = '0;
        aluControl   = '0;
        regWrite     = '0;
        regWriteData = '0;
        write        = 1'b0;
        write_to_reg = 1'b0;
        done         = (state_q == S_DONE);
        illegal      = (state_q == S_DONE) && (op == OP_ILL);
        if (in_flight && op == OP_ALU) begin
            reg1Addr   = ir_q[RS_HI:RS_LO];
            reg2Addr   = ir_q[RT_HI:RT_LO];
            aluControl = ir_q[FN_HI:FN_LO];
        end
        if (in_flight && op == OP_LI) begin
            regWriteData = {{16{ir_q[IMM_HI]}}, ir_q[IMM_HI:IMM_LO]};
            write        = (state_q != S_EXEC);
        end
        if (state_q == S_WRITE) begin
            regWrite     = rd;
            write_to_reg = (rd != 5'd0);
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed-vector bench for alu_sequencer; cycle numbers count from the accept edge.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [4:0]  reg1Addr, reg2Addr, regWrite;
    logic [3:0]  aluControl;
    logic [31:0] regWriteData;
    logic        write, write_to_reg, busy, done, illegal;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] ALU_I   = {2'b01, 4'b0, 5'd3, 5'd4, 5'd5, 7'b0, 4'd2};
    localparam logic [31:0] LI_I    = {2'b10, 4'b0, 5'd7, 5'd0, 16'hFFFE};
    localparam logic [31:0] LI_R0   = {2'b10, 4'b0, 5'd0, 5'd0, 16'h0005};
    localparam logic [31:0] LI_R9   = {2'b10, 4'b0, 5'd9, 5'd0, 16'h0012};
    localparam logic [31:0] ILL_I   = {2'b11, 30'h0ABC_DEF1};
    localparam logic [31:0] NOP_I   = 32'h0000_0000;

    alu_sequencer #(.EXEC_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .reg1Addr(reg1Addr), .reg2Addr(reg2Addr),
        .regWrite(regWrite), .aluControl(aluControl), .regWriteData(regWriteData),
        .write(write), .write_to_reg(write_to_reg), .busy(busy), .done(done),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic accept(input logic [31:0] w);
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = w;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; instr_valid = 1'b0; instr = '0;
        #2;
        checks++;
        if ({instr_ready, reg1Addr, reg2Addr, regWrite, aluControl, regWriteData,
             write, write_to_reg, busy, done, illegal} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b busy=%b done=%b wtr=%b rwd=%h required all 0",
                     instr_ready, busy, done, write_to_reg, regWriteData);
        end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (instr_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got rdy=%b busy=%b required rdy=1 busy=0", instr_ready, busy);
        end
    endtask

    task automatic test_alu;
        accept(ALU_I);
        instr = 32'hFFFF_FFFF;
        for (int c = 1; c <= 7; c++) begin
            logic ea;
            ea = (c <= 5);
            checks++;
            if (reg1Addr !== (ea ? 5'd3 : 5'd0) || reg2Addr !== (ea ? 5'd4 : 5'd0) ||
                aluControl !== (ea ? 4'd2 : 4'd0)) begin
                errors++;
                $display("FAIL alu_operands cyc %0d got %0d/%0d/%0d required %0d/%0d/%0d", c,
                         reg1Addr, reg2Addr, aluControl, ea ? 3 : 0, ea ? 4 : 0, ea ? 2 : 0);
            end
            checks++;
            if (write_to_reg !== (c == 5) || regWrite !== ((c == 5) ? 5'd5 : 5'd0) || write !== 1'b0) begin
                errors++;
                $display("FAIL alu_write cyc %0d got wtr=%b rw=%0d wr=%b required wtr=%b rw=%0d wr=0",
                         c, write_to_reg, regWrite, write, c == 5, (c == 5) ? 5 : 0);
            end
            checks++;
            if (done !== (c == 6) || busy !== (c <= 6) || instr_ready !== (c == 7) || illegal !== 1'b0) begin
                errors++;
                $display("FAIL alu_ctrl cyc %0d got done=%b busy=%b rdy=%b ill=%b required %b/%b/%b/0",
                         c, done, busy, instr_ready, illegal, c == 6, c <= 6, c == 7);
            end
            if (c < 7) next_cycle();
        end
    endtask

    task automatic test_li(input logic [31:0] w, input logic [4:0] rd, input logic [31:0] data);
        accept(w);
        instr = ALU_I;
        for (int c = 1; c <= 5; c++) begin
            checks++;
            if (write !== (c <= 3) || (c <= 3 && regWriteData !== data)) begin
                errors++;
                $display("FAIL li_data cyc %0d got wr=%b rwd=%h required wr=%b rwd=%h",
                         c, write, regWriteData, c <= 3, data);
            end
            checks++;
            if (write_to_reg !== (c == 3 && rd != 5'd0) || regWrite !== ((c == 3) ? rd : 5'd0) ||
                reg1Addr !== 5'd0 || aluControl !== 4'd0) begin
                errors++;
                $display("FAIL li_write cyc %0d got wtr=%b rw=%0d r1=%0d fn=%0d required wtr=%b rw=%0d",
                         c, write_to_reg, regWrite, reg1Addr, aluControl, c == 3 && rd != 0, (c == 3) ? rd : 0);
            end
            checks++;
            if (done !== (c == 4) || instr_ready !== (c == 5)) begin
                errors++;
                $display("FAIL li_done cyc %0d got done=%b rdy=%b required %b/%b",
                         c, done, instr_ready, c == 4, c == 5);
            end
            if (c < 5) next_cycle();
        end
    endtask

    task automatic test_short(input logic [31:0] w, input logic ill);
        accept(w);
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (done !== (c == 2) || illegal !== (ill && c == 2) || instr_ready !== (c == 3) ||
                write_to_reg !== 1'b0 || write !== 1'b0) begin
                errors++;
                $display("FAIL short_op%b cyc %0d got done=%b ill=%b rdy=%b wtr=%b wr=%b required %b/%b/%b/0/0",
                         ill, c, done, illegal, instr_ready, write_to_reg, write, c == 2, ill && c == 2, c == 3);
            end
            if (c < 3) next_cycle();
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = LI_R9;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 7; c++) begin
            instr = (c < 4) ? (ALU_I ^ c) : NOP_I;
            checks++;
            if (c <= 3 && (regWriteData !== 32'h12 || reg1Addr !== 5'd0 || write !== 1'b1)) begin
                errors++;
                $display("FAIL b2b_hold cyc %0d got rwd=%h r1=%0d wr=%b required 12/0/1",
                         c, regWriteData, reg1Addr, write);
            end
            checks++;
            if (write_to_reg !== (c == 3) || regWrite !== ((c == 3) ? 5'd9 : 5'd0)) begin
                errors++;
                $display("FAIL b2b_write cyc %0d got wtr=%b rw=%0d required %b/%0d",
                         c, write_to_reg, regWrite, c == 3, (c == 3) ? 9 : 0);
            end
            checks++;
            if (done !== (c == 4 || c == 7) || instr_ready !== (c == 5) || busy !== (c != 5)) begin
                errors++;
                $display("FAIL b2b_ctrl cyc %0d got done=%b rdy=%b busy=%b required %b/%b/%b",
                         c, done, instr_ready, busy, c == 4 || c == 7, c == 5, c != 5);
            end
            if (c == 6) instr_valid = 1'b0;
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_exec;
        accept(ALU_I);
        next_cycle();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({instr_ready, reg1Addr, reg2Addr, regWrite, aluControl, regWriteData,
             write, write_to_reg, busy, done, illegal} !== '0) begin
            errors++;
            $display("FAIL mid_reset_async got rdy=%b busy=%b r1=%0d fn=%0d required all 0",
                     instr_ready, busy, reg1Addr, aluControl);
        end
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            checks++;
            if (write_to_reg !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_hold got wtr=%b busy=%b required 0/0", write_to_reg, busy);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_ready got %b required 1", instr_ready);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_li(LI_I, 5'd7, 32'hFFFF_FFFE);
        test_li(LI_R0, 5'd0, 32'h0000_0005);
        test_short(ILL_I, 1'b1);
        test_short(NOP_I, 1'b0);
        test_back_to_back();
        test_reset_mid_exec();
        test_alu();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
